// File: rtl/whack_input_cond_if.sv
// Board-side signal bundle for the whack-a-mole input conditioner.
// The master drives the raw inputs and consumes the conditioned outputs; the slave is the conditioner.
interface whack_input_cond_if;
    logic       BtnC_raw;
    logic       BtnU_raw;
    logic       BtnL_raw;
    logic       BtnR_raw;
    logic       Ack_raw;
    logic [8:0] Sw_raw;

    logic       BtnC_p;
    logic       BtnU_p;
    logic       BtnL_p;
    logic       BtnR_p;
    logic       Ack_p;
    logic [8:0] Sw_lvl;
    logic       hit_valid;
    logic [3:0] hit_index;
    logic       hit_drop;
    logic       ready;

    modport master (
        output BtnC_raw, BtnU_raw, BtnL_raw, BtnR_raw, Ack_raw, Sw_raw,
        input  BtnC_p, BtnU_p, BtnL_p, BtnR_p, Ack_p, Sw_lvl,
        input  hit_valid, hit_index, hit_drop, ready
    );

    modport slave (
        input  BtnC_raw, BtnU_raw, BtnL_raw, BtnR_raw, Ack_raw, Sw_raw,
        output BtnC_p, BtnU_p, BtnL_p, BtnR_p, Ack_p, Sw_lvl,
        output hit_valid, hit_index, hit_drop, ready
    );
endinterface

// File: rtl/whack_input_cond.sv
// Synchronise/debounce buttons and mole switches; emit button pulses, switch levels and hit events.
// Channels 0..4 are BtnC, BtnU, BtnL, BtnR, Ack; channels 5..13 are Sw[0..8].
module whack_input_cond #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic              Clk,
    input  logic              Reset,
    whack_input_cond_if.slave io
);
    localparam int NCH   = 14;
    localparam int NBTN  = 5;
    localparam int SET_W = $clog2(DEBOUNCE_CYCLES + 3);
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(DEBOUNCE_CYCLES + 2);

    typedef enum logic [0:0] {
        SETTLE = 1'b0,
        ARMED  = 1'b1
    } arm_state_e;

    logic [NCH-1:0]            raw_s;
    logic [NCH-1:0]            s1_q;
    logic [NCH-1:0]            s2_q;
    logic [NCH-1:0]            stable_q;
    logic [NCH-1:0]            stable_d;
    logic [NCH-1:0][CNT_W-1:0] cnt_q;
    logic [NCH-1:0][CNT_W-1:0] cnt_d;

    logic [NBTN-1:0] pulse_q;
    logic [NBTN-1:0] pulse_d;
    logic            hit_valid_q;
    logic            hit_valid_d;
    logic [3:0]      hit_index_q;
    logic [3:0]      hit_index_d;
    logic            hit_drop_q;
    logic            hit_drop_d;

    arm_state_e      state_q;
    logic [SET_W-1:0] settle_q;
    logic            ready_q;

    logic [NBTN-1:0] rise_s;
    logic [8:0]      tog_s;
    logic [3:0]      low_s;
    logic            multi_s;
    logic            armed_s;

    assign raw_s = {io.Sw_raw, io.Ack_raw, io.BtnR_raw, io.BtnL_raw, io.BtnU_raw, io.BtnC_raw};

    // Per-channel debounce: any reversion to the stable value discards the accumulated count
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        for (int i = 0; i < NCH; i++) begin
            if (s2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                stable_d[i] = s2_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Edge detection on the debounced values, gated until the settling window has passed
    always_comb begin
        armed_s = (state_q == ARMED);
        rise_s  = stable_d[NBTN-1:0] & ~stable_q[NBTN-1:0];
        tog_s   = stable_d[NCH-1:NBTN] ^ stable_q[NCH-1:NBTN];
        multi_s = |(tog_s & (tog_s - 9'd1));
        low_s   = 4'hF;
        for (int j = 8; j >= 0; j--) begin
            low_s = tog_s[j] ? 4'(j) : low_s;
        end
        pulse_d     = armed_s ? rise_s : {NBTN{1'b0}};
        hit_valid_d = armed_s && (tog_s != 9'd0);
        hit_drop_d  = armed_s && multi_s;
        if (armed_s && (tog_s != 9'd0)) begin
            hit_index_d = low_s;
        end else begin
            hit_index_d = hit_index_q;
        end
    end

    // Synchroniser, debounce state and registered event outputs
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            s1_q        <= '0;
            s2_q        <= '0;
            stable_q    <= '0;
            cnt_q       <= '0;
            pulse_q     <= '0;
            hit_valid_q <= 1'b0;
            hit_index_q <= 4'hF;
            hit_drop_q  <= 1'b0;
        end else begin
            s1_q        <= raw_s;
            s2_q        <= s1_q;
            stable_q    <= stable_d;
            cnt_q       <= cnt_d;
            pulse_q     <= pulse_d;
            hit_valid_q <= hit_valid_d;
            hit_index_q <= hit_index_d;
            hit_drop_q  <= hit_drop_d;
        end
    end

    // Arming FSM: hold off events until inputs present at reset release have been absorbed
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= SETTLE;
            settle_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            case (state_q)
                SETTLE: begin
                    if (settle_q == SETTLE_LAST) begin
                        state_q <= ARMED;
                        ready_q <= 1'b1;
                    end else begin
                        settle_q <= settle_q + SET_W'(1);
                    end
                end
                ARMED: begin
                    state_q <= ARMED;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q  <= SETTLE;
                    settle_q <= '0;
                    ready_q  <= 1'b0;
                end
            endcase
        end
    end

    assign io.BtnC_p    = pulse_q[0];
    assign io.BtnU_p    = pulse_q[1];
    assign io.BtnL_p    = pulse_q[2];
    assign io.BtnR_p    = pulse_q[3];
    assign io.Ack_p     = pulse_q[4];
    assign io.Sw_lvl    = stable_q[NCH-1:NBTN];
    assign io.hit_valid = hit_valid_q;
    assign io.hit_index = hit_index_q;
    assign io.hit_drop  = hit_drop_q;
    assign io.ready     = ready_q;
endmodule

// File: tb/tb_whack_input_cond.sv
// Bench for whack_input_cond: directed scenarios plus random toggling, checked every cycle
// against a sliding-window model of the debounce rule.
module tb_whack_input_cond;
    localparam int D   = 4;
    localparam int NCH = 14;

    logic clk;
    logic Reset;
    whack_input_cond_if bus ();

    whack_input_cond #(.DEBOUNCE_CYCLES(D), .CNT_W(4)) dut (
        .Clk   (clk),
        .Reset (Reset),
        .io    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int pulse_cnt [5];
    int pulse_at;
    int cyc;

    // Raw vector: bits 0..4 = C,U,L,R,Ack; bits 5..13 = Sw[0..8]
    logic [NCH-1:0] raw_v;

    // Model: m_hist[k] holds the raw vector sampled k edges ago
    logic [NCH-1:0] m_hist [1:D+1];
    logic [NCH-1:0] m_stable;
    int             m_edges;
    logic [4:0]     exp_pulse;
    logic           exp_hv;
    logic [3:0]     exp_hi;
    logic           exp_hd;
    logic           exp_ready;

    task automatic apply_raw();
        bus.BtnC_raw = raw_v[0];
        bus.BtnU_raw = raw_v[1];
        bus.BtnL_raw = raw_v[2];
        bus.BtnR_raw = raw_v[3];
        bus.Ack_raw  = raw_v[4];
        bus.Sw_raw   = raw_v[13:5];
    endtask

    task automatic m_reset();
        for (int k = 1; k <= D + 1; k++) m_hist[k] = '0;
        m_stable  = '0;
        m_edges   = 0;
        exp_pulse = 5'd0;
        exp_hv    = 1'b0;
        exp_hi    = 4'hF;
        exp_hd    = 1'b0;
        exp_ready = 1'b0;
    endtask

    // A channel flips once its synchronised input has disagreed for D consecutive cycles
    task automatic m_edge(input logic [NCH-1:0] raw_now);
        logic [NCH-1:0] nxt;
        logic [8:0]     tog;
        bit             armed;
        bit             all_diff;
        nxt = m_stable;
        for (int i = 0; i < NCH; i++) begin
            all_diff = 1'b1;
            for (int k = 2; k <= D + 1; k++)
                if (m_hist[k][i] == m_stable[i]) all_diff = 1'b0;
            if (all_diff) nxt[i] = ~m_stable[i];
        end
        for (int k = D + 1; k >= 2; k--) m_hist[k] = m_hist[k-1];
        m_hist[1] = raw_now;
        armed = (m_edges >= D + 3);
        m_edges++;
        tog = nxt[13:5] ^ m_stable[13:5];
        exp_pulse = armed ? (nxt[4:0] & ~m_stable[4:0]) : 5'd0;
        exp_hv = armed && (tog != 9'd0);
        exp_hd = armed && ($countones(tog) > 1);
        if (exp_hv) begin
            for (int s = 0; s < 9; s++)
                if (tog[s]) begin exp_hi = 4'(s); break; end
        end
        exp_ready = (m_edges >= D + 3);
        m_stable = nxt;
    endtask

    task automatic check_outputs();
        logic [4:0] got_pulse;
        got_pulse = {bus.Ack_p, bus.BtnR_p, bus.BtnL_p, bus.BtnU_p, bus.BtnC_p};
        checks++;
        assert (got_pulse === exp_pulse) else begin
            errors++; $error("FAIL btn_pulse got=%b exp=%b t=%0t", got_pulse, exp_pulse, $time);
        end
        checks++;
        assert (bus.Sw_lvl === m_stable[13:5]) else begin
            errors++; $error("FAIL sw_lvl got=%b exp=%b t=%0t", bus.Sw_lvl, m_stable[13:5], $time);
        end
        checks++;
        assert ({bus.hit_valid, bus.hit_index, bus.hit_drop} === {exp_hv, exp_hi, exp_hd}) else begin
            errors++; $error("FAIL hit v/i/d got=%b/%h/%b exp=%b/%h/%b t=%0t",
                             bus.hit_valid, bus.hit_index, bus.hit_drop, exp_hv, exp_hi, exp_hd, $time);
        end
        checks++;
        assert (bus.ready === exp_ready) else begin
            errors++; $error("FAIL ready got=%b exp=%b t=%0t", bus.ready, exp_ready, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        m_edge(raw_v);
        #1;
        check_outputs();
        pulse_cnt[0] += int'(bus.BtnC_p);
        pulse_cnt[1] += int'(bus.BtnU_p);
        pulse_cnt[2] += int'(bus.BtnL_p);
        pulse_cnt[3] += int'(bus.BtnR_p);
        pulse_cnt[4] += int'(bus.Ack_p);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_counts();
        for (int b = 0; b < 5; b++) pulse_cnt[b] = 0;
    endtask

    // Asynchronous reset applied mid-cycle, released away from the clock edge
    task automatic do_reset(input int hold);
        int first_ready;
        Reset = 1'b1;
        m_reset();
        #1;
        check_outputs();
        for (int i = 0; i < hold; i++) @(posedge clk);
        #2;
        check_outputs();
        Reset = 1'b0;
        first_ready = 0;
        for (int c = 1; c <= D + 5; c++) begin
            tick();
            if (bus.ready && first_ready == 0) first_ready = c;
        end
        checks++;
        assert (first_ready == D + 3) else begin
            errors++; $error("FAIL ready_latency got=%0d exp=%0d", first_ready, D + 3);
        end
    endtask

    initial begin
        Reset = 1'b1;
        raw_v = '0;
        apply_raw();
        m_reset();
        clear_counts();
        #12;
        do_reset(2);

        // BtnL glitch of 3 sampled cycles: no pulse, no carried credit
        clear_counts();
        raw_v[2] = 1'b1; apply_raw(); ticks(3);
        raw_v[2] = 1'b0; apply_raw(); ticks(8);
        checks++;
        assert (pulse_cnt[2] == 0) else begin
            errors++; $error("FAIL btnl_glitch got=%0d exp=0", pulse_cnt[2]);
        end

        // BtnL held 20 cycles: exactly one pulse, visible after the 6th edge
        clear_counts();
        pulse_at = 0;
        raw_v[2] = 1'b1; apply_raw();
        for (cyc = 1; cyc <= 20; cyc++) begin
            tick();
            if (bus.BtnL_p && pulse_at == 0) pulse_at = cyc;
        end
        checks++;
        assert (pulse_cnt[2] == 1) else begin
            errors++; $error("FAIL btnl_hold_count got=%0d exp=1", pulse_cnt[2]);
        end
        checks++;
        assert (pulse_at == D + 2) else begin
            errors++; $error("FAIL btnl_latency got=%0d exp=%0d", pulse_at, D + 2);
        end
        raw_v[2] = 1'b0; apply_raw(); ticks(8);

        // Switch 6 up then down: two hits with index 6
        raw_v[5+6] = 1'b1; apply_raw(); ticks(10);
        raw_v[5+6] = 1'b0; apply_raw(); ticks(10);
        checks++;
        assert (bus.hit_index === 4'd6) else begin
            errors++; $error("FAIL sw6_index got=%h exp=6", bus.hit_index);
        end

        // Switches 2 and 5 rise together: one hit at index 2 with drop
        raw_v[5+2] = 1'b1; raw_v[5+5] = 1'b1; apply_raw(); ticks(10);
        checks++;
        assert (bus.Sw_lvl === 9'b000100100) else begin
            errors++; $error("FAIL sw25_lvl got=%b exp=000100100", bus.Sw_lvl);
        end

        // Switch 0 held through reset release: absorbed, no hit
        raw_v = '0; raw_v[5] = 1'b1; apply_raw();
        do_reset(3);
        ticks(6);
        checks++;
        assert ({bus.Sw_lvl[0], bus.hit_index} === {1'b1, 4'hF}) else begin
            errors++; $error("FAIL sw0_absorb got=%b/%h exp=1/f", bus.Sw_lvl[0], bus.hit_index);
        end

        // BtnU press interrupted by reset, then held: no pulse until a clean release and press
        raw_v = '0; apply_raw(); ticks(8);
        raw_v[1] = 1'b1; apply_raw(); ticks(3);
        clear_counts();
        do_reset(2);
        ticks(10);
        checks++;
        assert (pulse_cnt[1] == 0) else begin
            errors++; $error("FAIL btnu_after_reset got=%0d exp=0", pulse_cnt[1]);
        end
        raw_v[1] = 1'b0; apply_raw(); ticks(8);
        clear_counts();
        raw_v[1] = 1'b1; apply_raw(); ticks(10);
        checks++;
        assert (pulse_cnt[1] == 1) else begin
            errors++; $error("FAIL btnu_repress got=%0d exp=1", pulse_cnt[1]);
        end

        // Random segments: toggle one or two channels and hold for 1..8 cycles
        for (int seg = 0; seg < 250; seg++) begin
            int ch;
            ch = int'($urandom_range(0, NCH - 1));
            raw_v[ch] = ~raw_v[ch];
            if ($urandom_range(0, 5) == 0) begin
                ch = int'($urandom_range(5, NCH - 1));
                raw_v[ch] = ~raw_v[ch];
            end
            apply_raw();
            ticks(int'($urandom_range(1, 8)));
            if (seg == 120) do_reset(int'($urandom_range(1, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
